// File: rtl/match_controller_if.sv
// ---------------------------------------------------------------------------
// match_controller_if : player button requests in, committed actions out.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface match_controller_if;
  logic       btn1_valid;
  logic [2:0] btn1_action;
  logic       btn2_valid;
  logic [2:0] btn2_action;
  logic [2:0] action1;
  logic [2:0] action2;
  logic       actionEnable;

  modport master (
    output btn1_valid, btn1_action, btn2_valid, btn2_action,
    input  action1, action2, actionEnable
  );

  modport slave (
    input  btn1_valid, btn1_action, btn2_valid, btn2_action,
    output action1, action2, actionEnable
  );
endinterface

`default_nettype wire

// File: rtl/match_controller.sv
// ---------------------------------------------------------------------------
// match_controller : two-player turn sequencer (collect, issue, settle, check).
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module match_controller #(
  parameter logic [7:0] TIMEOUT   = 8'd200,
  parameter logic [7:0] MAX_TURNS = 8'd99
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         start,
  input  wire logic [1:0]   health1,
  input  wire logic [1:0]   health2,
  match_controller_if.slave bus,
  output logic              isGameOver,
  output logic [1:0]        winner,
  output logic [7:0]        turn_count,
  output logic [2:0]        fsm_state
);

  localparam logic [2:0] c_AWAIT     = 3'b010;
  localparam logic [7:0] c_TIMER_MAX = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_ISSUE   = 3'd2,
    S_SETTLE  = 3'd3,
    S_CHECK   = 3'd4,
    S_OVER    = 3'd5
  } state_t;

  state_t     r_state,      w_state_nxt;
  logic       r_lat1_valid, w_lat1_valid_nxt;
  logic       r_lat2_valid, w_lat2_valid_nxt;
  logic [2:0] r_lat1,       w_lat1_nxt;
  logic [2:0] r_lat2,       w_lat2_nxt;
  logic [7:0] r_timer,      w_timer_nxt;
  logic [2:0] r_action1,    w_action1_nxt;
  logic [2:0] r_action2,    w_action2_nxt;
  logic       r_action_en,  w_action_en_nxt;
  logic       r_game_over,  w_game_over_nxt;
  logic [1:0] r_winner,     w_winner_nxt;
  logic [7:0] r_turn_count, w_turn_count_nxt;

  logic       w_full1, w_full2;
  logic [2:0] w_act1,  w_act2;
  logic [7:0] w_turn_inc;
  logic [1:0] w_winner_calc;
  logic       w_end_match;

  // A player counts as full this cycle if already latched or strobing now,
  // so both actions arriving in the first COLLECT cycle commit immediately.
  always_comb begin
    w_full1    = r_lat1_valid | bus.btn1_valid;
    w_full2    = r_lat2_valid | bus.btn2_valid;
    w_act1     = r_lat1_valid ? r_lat1 : (bus.btn1_valid ? bus.btn1_action : c_AWAIT);
    w_act2     = r_lat2_valid ? r_lat2 : (bus.btn2_valid ? bus.btn2_action : c_AWAIT);
    w_turn_inc = r_turn_count + 8'd1;
  end

  always_comb begin
    w_winner_calc = 2'b11;
    if (health1 == 2'd0 && health2 == 2'd0)
      w_winner_calc = 2'b11;
    else if (health2 == 2'd0)
      w_winner_calc = 2'b01;
    else if (health1 == 2'd0)
      w_winner_calc = 2'b10;
    else if (health1 > health2)
      w_winner_calc = 2'b01;
    else if (health2 > health1)
      w_winner_calc = 2'b10;
    w_end_match = (health1 == 2'd0) || (health2 == 2'd0) || (w_turn_inc == MAX_TURNS);
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_lat1_valid_nxt = r_lat1_valid;
    w_lat2_valid_nxt = r_lat2_valid;
    w_lat1_nxt       = r_lat1;
    w_lat2_nxt       = r_lat2;
    w_timer_nxt      = r_timer;
    w_action1_nxt    = r_action1;
    w_action2_nxt    = r_action2;
    w_winner_nxt     = r_winner;
    w_turn_count_nxt = r_turn_count;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt      = S_COLLECT;
          w_lat1_valid_nxt = 1'b0;
          w_lat2_valid_nxt = 1'b0;
          w_timer_nxt      = 8'd0;
          w_turn_count_nxt = 8'd0;
          w_winner_nxt     = 2'b00;
        end
      end
      S_COLLECT: begin
        if (bus.btn1_valid && !r_lat1_valid) begin
          w_lat1_valid_nxt = 1'b1;
          w_lat1_nxt       = bus.btn1_action;
        end
        if (bus.btn2_valid && !r_lat2_valid) begin
          w_lat2_valid_nxt = 1'b1;
          w_lat2_nxt       = bus.btn2_action;
        end
        if (r_timer != c_TIMER_MAX)
          w_timer_nxt = r_timer + 8'd1;
        if ((w_full1 && w_full2) || (r_timer >= TIMEOUT - 8'd1)) begin
          w_state_nxt   = S_ISSUE;
          w_action1_nxt = w_act1;
          w_action2_nxt = w_act2;
        end
      end
      S_ISSUE:  w_state_nxt = S_SETTLE;
      S_SETTLE: w_state_nxt = S_CHECK;
      S_CHECK: begin
        w_turn_count_nxt = w_turn_inc;
        if (w_end_match) begin
          w_state_nxt  = S_OVER;
          w_winner_nxt = w_winner_calc;
        end else begin
          w_state_nxt      = S_COLLECT;
          w_lat1_valid_nxt = 1'b0;
          w_lat2_valid_nxt = 1'b0;
          w_timer_nxt      = 8'd0;
        end
      end
      S_OVER:   w_state_nxt = S_OVER;
      default:  w_state_nxt = S_IDLE;
    endcase

    // Strobe and game-over flags are registered copies of the next state.
    w_action_en_nxt = (w_state_nxt == S_ISSUE);
    w_game_over_nxt = (w_state_nxt == S_OVER);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_lat1_valid <= 1'b0;
      r_lat2_valid <= 1'b0;
      r_lat1       <= c_AWAIT;
      r_lat2       <= c_AWAIT;
      r_timer      <= 8'd0;
      r_action1    <= c_AWAIT;
      r_action2    <= c_AWAIT;
      r_action_en  <= 1'b0;
      r_game_over  <= 1'b0;
      r_winner     <= 2'b00;
      r_turn_count <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_lat1_valid <= w_lat1_valid_nxt;
      r_lat2_valid <= w_lat2_valid_nxt;
      r_lat1       <= w_lat1_nxt;
      r_lat2       <= w_lat2_nxt;
      r_timer      <= w_timer_nxt;
      r_action1    <= w_action1_nxt;
      r_action2    <= w_action2_nxt;
      r_action_en  <= w_action_en_nxt;
      r_game_over  <= w_game_over_nxt;
      r_winner     <= w_winner_nxt;
      r_turn_count <= w_turn_count_nxt;
    end
  end

  assign bus.action1      = r_action1;
  assign bus.action2      = r_action2;
  assign bus.actionEnable = r_action_en;
  assign isGameOver       = r_game_over;
  assign winner           = r_winner;
  assign turn_count       = r_turn_count;
  assign fsm_state        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_match_controller.sv
// ---------------------------------------------------------------------------
// tb_match_controller : directed bench for match_controller.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_match_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] health1, health2;
  logic       isGameOver;
  logic [1:0] winner;
  logic [7:0] turn_count;
  logic [2:0] fsm_state;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  match_controller_if bus ();

  match_controller #(.TIMEOUT(8'd200), .MAX_TURNS(8'd3)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .health1    (health1),
    .health2    (health2),
    .bus        (bus),
    .isGameOver (isGameOver),
    .winner     (winner),
    .turn_count (turn_count),
    .fsm_state  (fsm_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start           = 1'b0;
    bus.btn1_valid  = 1'b0;
    bus.btn2_valid  = 1'b0;
    bus.btn1_action = 3'b000;
    bus.btn2_action = 3'b000;
  endtask

  task automatic do_reset();
    idle_inputs();
    health1 = 2'd3;
    health2 = 2'd3;
    reset   = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic begin_match();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_collect", fsm_state, 3'd1);
  endtask

  // Both players strobe in one cycle; returns with the DUT in ISSUE.
  task automatic both(input logic [2:0] a1, input logic [2:0] a2);
    bus.btn1_valid  = 1'b1;
    bus.btn1_action = a1;
    bus.btn2_valid  = 1'b1;
    bus.btn2_action = a2;
    tick();
    bus.btn1_valid = 1'b0;
    bus.btn2_valid = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    health1 = 2'd3;
    health2 = 2'd3;
    idle_inputs();
    #12;
    check("rst_state",   fsm_state, 3'd0);
    check("rst_action1", bus.action1, 3'b010);
    check("rst_action2", bus.action2, 3'b010);
    check("rst_en",      bus.actionEnable, 1'b0);
    check("rst_over",    isGameOver, 1'b0);
    check("rst_winner",  winner, 2'b00);
    check("rst_turns",   turn_count, 8'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("idle_hold", fsm_state, 3'd0);

    // Simultaneous valids commit in the minimum four-cycle turn.
    begin_match();
    both(3'b110, 3'b000);
    check("issue_state", fsm_state, 3'd2);
    check("issue_en",    bus.actionEnable, 1'b1);
    check("issue_a1",    bus.action1, 3'b110);
    check("issue_a2",    bus.action2, 3'b000);
    tick();
    check("settle_state", fsm_state, 3'd3);
    check("settle_en",    bus.actionEnable, 1'b0);
    check("settle_a1",    bus.action1, 3'b110);
    tick();
    check("check_state", fsm_state, 3'd4);
    tick();
    check("turn1_state", fsm_state, 3'd1);
    check("turn1_count", turn_count, 8'd1);

    // Second strobe from an already-latched player is ignored.
    bus.btn1_valid  = 1'b1;
    bus.btn1_action = 3'b100;
    tick();
    bus.btn1_action = 3'b111;
    tick();
    check("p1_only_waits", fsm_state, 3'd1);
    bus.btn1_valid  = 1'b0;
    bus.btn2_valid  = 1'b1;
    bus.btn2_action = 3'b011;
    tick();
    bus.btn2_valid = 1'b0;
    check("first_wins_en", bus.actionEnable, 1'b1);
    check("first_wins_a1", bus.action1, 3'b100);
    check("first_wins_a2", bus.action2, 3'b011);
    tick();
    tick();
    tick();
    check("turn2_count", turn_count, 8'd2);

    // Timeout turn, which is also the last turn with equal health.
    bus.btn1_valid  = 1'b1;
    bus.btn1_action = 3'b001;
    tick();
    bus.btn1_valid = 1'b0;
    repeat (198) tick();
    check("timeout_not_yet", fsm_state, 3'd1);
    tick();
    check("timeout_state", fsm_state, 3'd2);
    check("timeout_en",    bus.actionEnable, 1'b1);
    check("timeout_a1",    bus.action1, 3'b001);
    check("timeout_a2",    bus.action2, 3'b010);
    tick();
    check("timeout_a1_hold", bus.action1, 3'b001);
    tick();
    tick();
    check("limit_state",  fsm_state, 3'd5);
    check("limit_over",   isGameOver, 1'b1);
    check("limit_winner", winner, 2'b11);
    check("limit_turns",  turn_count, 8'd3);
    start = 1'b1;
    bus.btn1_valid = 1'b1;
    bus.btn2_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("over_no_en", bus.actionEnable, 1'b0);
    end
    check("over_terminal", fsm_state, 3'd5);

    // Player 2 knocked out during SETTLE.
    do_reset();
    check("rerst_over",   isGameOver, 1'b0);
    check("rerst_winner", winner, 2'b00);
    check("rerst_turns",  turn_count, 8'd0);
    begin_match();
    both(3'b001, 3'b001);
    tick();
    health2 = 2'd0;
    health1 = 2'd2;
    tick();
    tick();
    check("ko2_state",  fsm_state, 3'd5);
    check("ko2_over",   isGameOver, 1'b1);
    check("ko2_winner", winner, 2'b01);
    check("ko2_turns",  turn_count, 8'd1);
    start = 1'b1;
    bus.btn1_valid = 1'b1;
    bus.btn2_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ko2_no_en", bus.actionEnable, 1'b0);
    end

    // Player 1 knocked out.
    do_reset();
    begin_match();
    both(3'b000, 3'b000);
    health1 = 2'd0;
    health2 = 2'd1;
    tick();
    tick();
    tick();
    check("ko1_winner", winner, 2'b10);

    // Turn limit with unequal health.
    do_reset();
    health1 = 2'd3;
    health2 = 2'd1;
    begin_match();
    for (int t = 0; t < 3; t++) begin
      both(3'b011, 3'b101);
      tick();
      tick();
      tick();
    end
    check("hp_limit_state",  fsm_state, 3'd5);
    check("hp_limit_winner", winner, 2'b01);

    // Reset asserted mid-ISSUE acts without a clock edge.
    do_reset();
    begin_match();
    both(3'b000, 3'b000);
    tick();
    tick();
    tick();
    both(3'b101, 3'b110);
    check("pre_rst_en", bus.actionEnable, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    check("async_en",    bus.actionEnable, 1'b0);
    check("async_state", fsm_state, 3'd0);
    check("async_turns", turn_count, 8'd0);
    check("async_a1",    bus.action1, 3'b010);
    tick();
    reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
